// File: rtl/spi_frame_ctrl_if.sv
// spi_frame_ctrl_if: byte-level handshake between the SPI byte shifter,
// the frame controller and the register / sample-buffer read ports.
// The slave modport is the controller's view. The master modport is the
// view of the surrounding shifter, register file and buffer.
interface spi_frame_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int BUF_AW = 12
);
    logic              cs_n;
    logic              rx_valid;
    logic [7:0]        rx_byte;
    logic              tx_load;
    logic [7:0]        tx_byte;
    logic              reg_we;
    logic              reg_re;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic [7:0]        reg_rdata;
    logic              buf_re;
    logic [BUF_AW-1:0] buf_addr;
    logic [7:0]        buf_rdata;
    logic              clr_err;
    logic              busy;
    logic              err;

    modport slave (
        input  cs_n, rx_valid, rx_byte, tx_load, reg_rdata, buf_rdata, clr_err,
        output tx_byte, reg_we, reg_re, reg_addr, reg_wdata, buf_re, buf_addr,
               busy, err
    );

    modport master (
        output cs_n, rx_valid, rx_byte, tx_load, reg_rdata, buf_rdata, clr_err,
        input  tx_byte, reg_we, reg_re, reg_addr, reg_wdata, buf_re, buf_addr,
               busy, err
    );
endinterface

// File: rtl/spi_frame_ctrl.sv
// spi_frame_ctrl: parses each chip-select frame from the SPI byte shifter
// as command / address / data. It drives register writes and reads or
// sample-buffer reads, and prefetches read data into the transmit slot.
// Optional feature macro: SPI_FRAME_AUTOINC_EN. When it is defined, the
// address advances after every data byte or tx load (burst access). When it
// is undefined, the address stays fixed for the frame (FIFO-port access).
module spi_frame_ctrl #(
    parameter int ADDR_W = 8,
    parameter int BUF_AW = 12
) (
    input  logic            clk_i,
    input  logic            rst_i,
    spi_frame_ctrl_if.slave bus
);

`ifdef SPI_FRAME_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    typedef enum logic [3:0] {
        IDLE,
        CMD,
        ADDR_H,
        ADDR_L,
        WR_DATA,
        RD_FETCH,
        RD_WAIT,
        RD_DATA,
        DROP
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic              cs_prev_q;
    logic              cs_fall;
    logic              cmd_bad;

    logic              latch_cmd;
    logic              latch_hi;
    logic              latch_lo;
    logic              do_write;
    logic              do_capture;
    logic              rd_advance;
    logic              set_err;

    logic              is_read_q;
    logic              is_buf_q;
    logic [7:0]        addr_hi_q;
    logic [ADDR_W-1:0] reg_addr_q;
    logic [BUF_AW-1:0] buf_addr_q;
    logic [7:0]        wdata_q;
    logic [7:0]        tx_q;
    logic              we_q;
    logic              err_q;

    logic              reg_we;
    logic              reg_re;
    logic              buf_re;

    // cs_prev_q resets low, so a chip select that is already low when reset
    // is released never looks like a falling edge. The frame restarts only
    // after cs_n has been seen high.
    assign cs_fall = cs_prev_q & ~bus.cs_n;

    // Reserved bits must be zero. The buffer space is read-only.
    assign cmd_bad = (bus.rx_byte[5:0] != 6'd0) || (bus.rx_byte[6] && !bus.rx_byte[7]);

    // Strobes are suppressed in any cycle where cs_n is high.
    assign reg_we = we_q & ~bus.cs_n;
    assign reg_re = (state_q == RD_FETCH) & ~is_buf_q & ~bus.cs_n;
    assign buf_re = (state_q == RD_FETCH) &  is_buf_q & ~bus.cs_n;

    assign bus.reg_we    = reg_we;
    assign bus.reg_re    = reg_re;
    assign bus.buf_re    = buf_re;
    assign bus.reg_addr  = reg_addr_q;
    assign bus.buf_addr  = buf_addr_q;
    assign bus.reg_wdata = wdata_q;
    assign bus.tx_byte   = tx_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.err       = err_q;

    // Frame state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Chip-select history, used to detect the start of a frame
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cs_prev_q <= 1'b0;
        end else begin
            cs_prev_q <= bus.cs_n;
        end
    end

    // Next-state decode and per-cycle datapath controls; cs_n high overrides everything
    always_comb begin
        state_d    = state_q;
        latch_cmd  = 1'b0;
        latch_hi   = 1'b0;
        latch_lo   = 1'b0;
        do_write   = 1'b0;
        do_capture = 1'b0;
        rd_advance = 1'b0;
        set_err    = 1'b0;
        if (bus.cs_n) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d = CMD;
                    end
                end
                CMD: begin
                    if (bus.rx_valid) begin
                        if (cmd_bad) begin
                            set_err = 1'b1;
                            state_d = DROP;
                        end else begin
                            latch_cmd = 1'b1;
                            state_d   = bus.rx_byte[6] ? ADDR_H : ADDR_L;
                        end
                    end
                end
                ADDR_H: begin
                    if (bus.rx_valid) begin
                        latch_hi = 1'b1;
                        state_d  = ADDR_L;
                    end
                end
                ADDR_L: begin
                    if (bus.rx_valid) begin
                        latch_lo = 1'b1;
                        state_d  = is_read_q ? RD_FETCH : WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (bus.rx_valid) begin
                        do_write = 1'b1;
                    end
                end
                RD_FETCH: begin
                    state_d = RD_WAIT;
                end
                RD_WAIT: begin
                    do_capture = 1'b1;
                    state_d    = RD_DATA;
                end
                RD_DATA: begin
                    if (bus.tx_load) begin
                        rd_advance = 1'b1;
                        state_d    = RD_FETCH;
                    end
                end
                DROP: begin
                    state_d = DROP;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Command/address latches, write data, address advance, tx slot and sticky error
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            is_read_q  <= 1'b0;
            is_buf_q   <= 1'b0;
            addr_hi_q  <= 8'd0;
            reg_addr_q <= '0;
            buf_addr_q <= '0;
            wdata_q    <= 8'd0;
            tx_q       <= 8'd0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            we_q <= do_write;
            if (do_write) begin
                wdata_q <= bus.rx_byte;
            end
            if (latch_cmd) begin
                is_read_q <= bus.rx_byte[7];
                is_buf_q  <= bus.rx_byte[6];
            end
            if (latch_hi) begin
                addr_hi_q <= bus.rx_byte;
            end
            if (latch_lo) begin
                if (is_buf_q) begin
                    buf_addr_q <= BUF_AW'({addr_hi_q, bus.rx_byte});
                end else begin
                    reg_addr_q <= ADDR_W'(bus.rx_byte);
                end
            end
            if (AUTOINC && reg_we) begin
                reg_addr_q <= reg_addr_q + ADDR_W'(1);
            end
            if (AUTOINC && rd_advance) begin
                if (is_buf_q) begin
                    buf_addr_q <= buf_addr_q + BUF_AW'(1);
                end else begin
                    reg_addr_q <= reg_addr_q + ADDR_W'(1);
                end
            end
            if (bus.cs_n) begin
                tx_q <= 8'd0;
            end else if (do_capture) begin
                tx_q <= is_buf_q ? bus.buf_rdata : bus.reg_rdata;
            end
            if (set_err) begin
                err_q <= 1'b1;
            end else if (bus.clr_err) begin
                err_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// tb_spi_frame_ctrl: drives directed and randomized SPI frames into
// spi_frame_ctrl and compares the strobes, addresses and transmit bytes
// against a memory-level model of the frame protocol.
module tb_spi_frame_ctrl;

`ifdef SPI_FRAME_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    localparam int REG_SIZE = 256;
    localparam int BUF_SIZE = 4096;

    logic clk;
    logic rst;

    int check_count;
    int pass_count;

    logic [7:0] regmem [REG_SIZE];
    logic [7:0] bufmem [BUF_SIZE];
    logic [7:0] data_seq [4];

    int wr_log [$];
    int rd_log [$];

    spi_frame_ctrl_if #(.ADDR_W(8), .BUF_AW(12)) bus ();

    spi_frame_ctrl #(.ADDR_W(8), .BUF_AW(12)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file and sample buffer: data appears the cycle after the strobe only
    always @(posedge clk) begin
        if (bus.reg_re) bus.reg_rdata <= regmem[bus.reg_addr];
        else            bus.reg_rdata <= 8'($urandom);
        if (bus.buf_re) bus.buf_rdata <= bufmem[bus.buf_addr];
        else            bus.buf_rdata <= 8'($urandom);
    end

    // Log every strobe the DUT issues
    always @(negedge clk) begin
        if (bus.reg_we) wr_log.push_back((32'(bus.reg_addr) << 8) | 32'(bus.reg_wdata));
        if (bus.reg_re) rd_log.push_back(32'(bus.reg_addr));
        if (bus.buf_re) rd_log.push_back(32'h10000 | 32'(bus.buf_addr));
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got === exp) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int expAddr(input int base, input int k, input int modw);
        return AUTOINC ? (base + k) % modw : base;
    endfunction

    function automatic logic [7:0] memAt(input bit is_buf, input int a);
        return is_buf ? bufmem[a] : regmem[a];
    endfunction

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        bus.rx_byte  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic pulseTxLoad();
        bus.tx_load = 1'b1;
        @(negedge clk);
        bus.tx_load = 1'b0;
    endtask

    task automatic startFrame();
        wr_log.delete();
        rd_log.delete();
        bus.cs_n = 1'b0;
        waitCycles(2);
    endtask

    task automatic endFrame();
        bus.cs_n = 1'b1;
        waitCycles(2);
    endtask

    task automatic clearErr();
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
    endtask

    task automatic runWrite(input logic [7:0] addr, input int n);
        startFrame();
        applyStimulus(8'h00);
        waitCycles(3);
        applyStimulus(addr);
        waitCycles(3);
        for (int j = 0; j < n; j++) begin
            applyStimulus(data_seq[j]);
            checkOutput("wr_we", 32'(bus.reg_we), 32'd1);
            checkOutput("wr_addr", 32'(bus.reg_addr), 32'(expAddr(int'(addr), j, REG_SIZE)));
            checkOutput("wr_data", 32'(bus.reg_wdata), 32'(data_seq[j]));
            waitCycles(3);
        end
        endFrame();
        checkOutput("wr_count", 32'(wr_log.size()), 32'(n));
        checkOutput("wr_noread", 32'(rd_log.size()), 32'd0);
        checkOutput("wr_err", 32'(bus.err), 32'd0);
    endtask

    task automatic runRead(input bit is_buf, input logic [7:0] hi, input logic [7:0] lo, input int nloads);
        int modw;
        int base;
        int a;
        modw = is_buf ? BUF_SIZE : REG_SIZE;
        base = is_buf ? (((int'(hi) << 8) | int'(lo)) % modw) : int'(lo);
        startFrame();
        applyStimulus(is_buf ? 8'hC0 : 8'h80);
        waitCycles(3);
        if (is_buf) begin
            applyStimulus(hi);
            waitCycles(3);
        end
        applyStimulus(lo);
        checkOutput("rd_strobe", 32'(is_buf ? bus.buf_re : bus.reg_re), 32'd1);
        waitCycles(1);
        checkOutput("tx_early", 32'(bus.tx_byte), 32'd0);
        waitCycles(1);
        checkOutput("tx_first", 32'(bus.tx_byte), 32'(memAt(is_buf, base)));
        for (int k = 1; k <= nloads; k++) begin
            pulseTxLoad();
            checkOutput("rd_restrobe", 32'(is_buf ? bus.buf_re : bus.reg_re), 32'd1);
            waitCycles(2);
            a = expAddr(base, k, modw);
            checkOutput("tx_next", 32'(bus.tx_byte), 32'(memAt(is_buf, a)));
            applyStimulus(8'($urandom));
            waitCycles(1);
        end
        endFrame();
        checkOutput("rd_count", 32'(rd_log.size()), 32'(nloads + 1));
        for (int k = 0; k < rd_log.size() && k <= nloads; k++) begin
            checkOutput("rd_addr", 32'(rd_log[k]),
                        32'((is_buf ? 32'h10000 : 32'h0) | expAddr(base, k, modw)));
        end
        checkOutput("rd_nowrite", 32'(wr_log.size()), 32'd0);
        checkOutput("tx_idle", 32'(bus.tx_byte), 32'd0);
    endtask

    task automatic runBadCmd(input logic [7:0] cmd);
        startFrame();
        applyStimulus(cmd);
        checkOutput("err_set", 32'(bus.err), 32'd1);
        waitCycles(3);
        applyStimulus(8'h10);
        waitCycles(3);
        applyStimulus(8'h55);
        waitCycles(3);
        checkOutput("drop_busy", 32'(bus.busy), 32'd1);
        endFrame();
        checkOutput("drop_nowrite", 32'(wr_log.size()), 32'd0);
        checkOutput("drop_noread", 32'(rd_log.size()), 32'd0);
        checkOutput("err_sticky", 32'(bus.err), 32'd1);
        clearErr();
        checkOutput("err_clear", 32'(bus.err), 32'd0);
    endtask

    // Watchdog so a stuck run still terminates
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: time limit reached, %0d/%0d checks passed so far", pass_count, check_count);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, directed frames from the protocol rules, then random frames
    initial begin
        int kind;
        int n;
        logic [7:0] cmd;
        check_count  = 0;
        pass_count   = 0;
        rst          = 1'b1;
        bus.cs_n     = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_byte  = 8'h00;
        bus.tx_load  = 1'b0;
        bus.clr_err  = 1'b0;
        for (int i = 0; i < REG_SIZE; i++) regmem[i] = 8'(i ^ 8'h55);
        for (int i = 0; i < BUF_SIZE; i++) bufmem[i] = 8'($urandom);

        waitCycles(3);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_err", 32'(bus.err), 32'd0);
        checkOutput("rst_tx", 32'(bus.tx_byte), 32'd0);
        checkOutput("rst_reg_addr", 32'(bus.reg_addr), 32'd0);
        checkOutput("rst_buf_addr", 32'(bus.buf_addr), 32'd0);
        checkOutput("rst_wdata", 32'(bus.reg_wdata), 32'd0);
        checkOutput("rst_strobes", 32'({bus.reg_we, bus.reg_re, bus.buf_re}), 32'd0);
        rst = 1'b0;
        waitCycles(2);

        $display("[TB] directed register writes");
        data_seq[0] = 8'hAA;
        data_seq[1] = 8'hBB;
        runWrite(8'h10, 2);
        data_seq[0] = 8'h01;
        data_seq[1] = 8'h02;
        runWrite(8'h20, 2);

        $display("[TB] directed reads");
        runRead(1'b0, 8'h00, 8'hFF, 3);
        runRead(1'b1, 8'h0F, 8'hFE, 2);

        $display("[TB] protocol errors");
        runBadCmd(8'h41);
        runBadCmd(8'h40);
        startFrame();
        bus.rx_byte  = 8'h01;
        bus.rx_valid = 1'b1;
        bus.clr_err  = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.clr_err  = 1'b0;
        checkOutput("err_set_wins", 32'(bus.err), 32'd1);
        endFrame();
        clearErr();
        checkOutput("err_clear2", 32'(bus.err), 32'd0);

        $display("[TB] cs_n rising with a data byte");
        startFrame();
        applyStimulus(8'h00);
        waitCycles(3);
        applyStimulus(8'h30);
        waitCycles(3);
        bus.rx_byte  = 8'h77;
        bus.rx_valid = 1'b1;
        bus.cs_n     = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        checkOutput("cs_win_we", 32'(bus.reg_we), 32'd0);
        checkOutput("cs_win_busy", 32'(bus.busy), 32'd0);
        waitCycles(3);
        checkOutput("cs_win_log", 32'(wr_log.size()), 32'd0);

        $display("[TB] reset in mid-frame");
        startFrame();
        applyStimulus(8'h00);
        waitCycles(3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        waitCycles(1);
        checkOutput("rst_mid_busy", 32'(bus.busy), 32'd0);
        applyStimulus(8'h00);
        waitCycles(3);
        applyStimulus(8'h40);
        waitCycles(3);
        applyStimulus(8'h12);
        waitCycles(3);
        checkOutput("rst_no_restart", 32'(bus.busy), 32'd0);
        checkOutput("rst_no_write", 32'(wr_log.size()), 32'd0);
        endFrame();

        $display("[TB] random frames");
        for (int i = 0; i < REG_SIZE; i++) regmem[i] = 8'($urandom);
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: begin
                    n = $urandom_range(1, 4);
                    for (int j = 0; j < 4; j++) data_seq[j] = 8'($urandom);
                    runWrite(8'($urandom), n);
                end
                1: runRead(1'b0, 8'h00, 8'($urandom), $urandom_range(0, 3));
                2: runRead(1'b1, 8'($urandom), 8'($urandom), $urandom_range(0, 3));
                default: begin
                    if ($urandom_range(0, 1) == 1) cmd = 8'h40;
                    else cmd = {2'($urandom), 6'($urandom_range(1, 63))};
                    runBadCmd(cmd);
                end
            endcase
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
